// File: rtl/lif_if.sv
// lif_if
// Bundles the setup, control and status signals of a lif_layer.
//   master : the side that drives setup/execute/monitor select (testbench or host)
//   slave  : the lif_layer itself
// Signals:
//   setup_en     setup write strobe
//   setup_sel    setup target selector (3 bits)
//   setup_addr   neuron index for weight writes
//   data_in      setup data byte
//   execute      request one timestep
//   mon_sel      neuron whose membrane appears on membrane_out
//   spikes       spike vector of the last completed timestep
//   membrane_out membrane of neuron mon_sel
//   busy         timestep evaluation in progress
//   step_done    one-cycle completion pulse
interface lif_if #(
  parameter int NEURONS       = 4,
  parameter int MEMBRANE_BITS = 8
);
  localparam int AW = (NEURONS > 1) ? $clog2(NEURONS) : 1;

  logic                     setup_en;
  logic [2:0]               setup_sel;
  logic [AW-1:0]            setup_addr;
  logic [7:0]               data_in;
  logic                     execute;
  logic [AW-1:0]            mon_sel;
  logic [NEURONS-1:0]       spikes;
  logic [MEMBRANE_BITS-1:0] membrane_out;
  logic                     busy;
  logic                     step_done;

  modport master (
    output setup_en, setup_sel, setup_addr, data_in, execute, mon_sel,
    input  spikes, membrane_out, busy, step_done
  );

  modport slave (
    input  setup_en, setup_sel, setup_addr, data_in, execute, mon_sel,
    output spikes, membrane_out, busy, step_done
  );
endinterface

// File: rtl/lif_layer.sv
// lif_layer
// A layer of leaky integrate-and-fire neurons sharing one binary input vector.
// Each neuron has a per-synapse sign weight (1 = +1, 0 = -1). One timestep
// evaluates the neurons sequentially, one per clock, then publishes the spike
// vector together with a one-cycle step_done pulse.
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    lif_if slave modport (setup writes, execute, monitor, status)
module lif_layer #(
  parameter int SYNAPSES      = 32,
  parameter int NEURONS       = 4,
  parameter int MEMBRANE_BITS = 8
) (
  input  logic clk,
  input  logic reset,
  lif_if.slave bus
);

  localparam int AW = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  localparam int SW = $clog2(SYNAPSES) + 2;
  localparam int MB = MEMBRANE_BITS;
  localparam int CW = MB + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EVAL = 1'b1;

  localparam logic [2:0] SEL_INPUTS    = 3'b000;
  localparam logic [2:0] SEL_WEIGHTS   = 3'b001;
  localparam logic [2:0] SEL_THRESHOLD = 3'b010;
  localparam logic [2:0] SEL_SHIFT     = 3'b011;
  localparam logic [2:0] SEL_REFRACT   = 3'b100;
  localparam logic [2:0] SEL_RMODE     = 3'b101;

  logic [0:0]                state_q, state_d;
  logic [AW-1:0]             idx_q, idx_d;
  logic [SYNAPSES-1:0]       inputs_q, inputs_d;
  logic [SYNAPSES-1:0]       snap_q, snap_d;
  logic [SYNAPSES-1:0]       weights_q [NEURONS];
  logic [SYNAPSES-1:0]       weights_d [NEURONS];
  logic signed [MB-1:0]      threshold_q, threshold_d;
  logic [2:0]                shift_q, shift_d;
  logic [3:0]                refract_len_q, refract_len_d;
  logic                      reset_mode_q, reset_mode_d;
  logic signed [MB-1:0]      membrane_q [NEURONS];
  logic signed [MB-1:0]      membrane_d [NEURONS];
  logic [3:0]                refract_q [NEURONS];
  logic [3:0]                refract_d [NEURONS];
  logic [NEURONS-1:0]        spikes_q, spikes_d;
  logic [NEURONS-1:0]        acc_q, acc_d;
  logic                      step_done_q, step_done_d;

  logic [SYNAPSES-1:0]       cur_w;
  logic signed [MB-1:0]      cur_m;
  logic                      refractory;
  logic signed [SW-1:0]      syn_sum;
  logic signed [SW-1:0]      eff_sum;
  logic signed [MB-1:0]      leaked;
  logic signed [CW-1:0]      cand_w;
  logic signed [MB-1:0]      cand;
  logic                      fire;
  logic signed [MB-1:0]      post_spike;
  logic signed [MB-1:0]      mon_value;

  // Datapath for the neuron currently addressed by idx_q. It is only consumed
  // while the state is EVAL, so it may compute freely in IDLE.
  always_comb begin
    cur_w      = weights_q[idx_q];
    cur_m      = membrane_q[idx_q];
    refractory = (refract_q[idx_q] != 4'd0);

    syn_sum = '0;
    for (int i = 0; i < SYNAPSES; i++) begin
      if (snap_q[i]) begin
        if (cur_w[i]) syn_sum = syn_sum + SW'(1);
        else          syn_sum = syn_sum - SW'(1);
      end
    end
    eff_sum = refractory ? '0 : syn_sum;

    // A shift of zero would otherwise wipe the membrane (m - m), so it is
    // treated as "no leak".
    if (shift_q == 3'd0) leaked = cur_m;
    else                 leaked = cur_m - (cur_m >>> shift_q);

    // One extra bit holds the exact sum; disagreeing top bits mean overflow.
    cand_w = {leaked[MB-1], leaked} + {{(CW-SW){eff_sum[SW-1]}}, eff_sum};
    if (cand_w[CW-1] != cand_w[CW-2]) begin
      if (cand_w[CW-1]) cand = {1'b1, {(MB-1){1'b0}}};
      else              cand = {1'b0, {(MB-1){1'b1}}};
    end else begin
      cand = cand_w[MB-1:0];
    end

    fire = (cand >= threshold_q);
    if (reset_mode_q) post_spike = cand - threshold_q;
    else              post_spike = '0;
  end

  // Next-state logic: setup writes and timestep acceptance in IDLE,
  // one neuron update per clock in EVAL.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    inputs_d      = inputs_q;
    snap_d        = snap_q;
    weights_d     = weights_q;
    threshold_d   = threshold_q;
    shift_d       = shift_q;
    refract_len_d = refract_len_q;
    reset_mode_d  = reset_mode_q;
    membrane_d    = membrane_q;
    refract_d     = refract_q;
    spikes_d      = spikes_q;
    acc_d         = acc_q;
    step_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.execute) begin
          state_d = EVAL;
          idx_d   = '0;
          snap_d  = inputs_q;
          acc_d   = '0;
        end
        if (bus.setup_en) begin
          case (bus.setup_sel)
            SEL_INPUTS: begin
              inputs_d = (inputs_q << 8) | SYNAPSES'(bus.data_in);
            end
            SEL_WEIGHTS: begin
              if (int'(bus.setup_addr) < NEURONS) begin
                weights_d[bus.setup_addr] =
                  (weights_q[bus.setup_addr] << 8) | SYNAPSES'(bus.data_in);
              end
            end
            SEL_THRESHOLD: begin
              // Only the low MB-1 bits are taken, so the threshold is never negative.
              threshold_d = '0;
              for (int b = 0; (b < MB - 1) && (b < 8); b++) begin
                threshold_d[b] = bus.data_in[b];
              end
            end
            SEL_SHIFT:   shift_d       = bus.data_in[2:0];
            SEL_REFRACT: refract_len_d = bus.data_in[3:0];
            SEL_RMODE:   reset_mode_d  = bus.data_in[0];
            default: ;
          endcase
        end
      end

      EVAL: begin
        if (fire) begin
          membrane_d[idx_q] = post_spike;
          refract_d[idx_q]  = refract_len_q;
        end else begin
          membrane_d[idx_q] = cand;
          if (refractory) refract_d[idx_q] = refract_q[idx_q] - 4'd1;
        end
        acc_d[idx_q] = fire;

        // Spikes are published only once the whole layer has been evaluated.
        if (idx_q == AW'(NEURONS - 1)) begin
          state_d     = IDLE;
          spikes_d    = acc_d;
          step_done_d = 1'b1;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers; reset also aborts an in-flight timestep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      inputs_q      <= '0;
      snap_q        <= '0;
      threshold_q   <= MB'(5);
      shift_q       <= 3'd0;
      refract_len_q <= 4'd0;
      reset_mode_q  <= 1'b0;
      spikes_q      <= '0;
      acc_q         <= '0;
      step_done_q   <= 1'b0;
      for (int n = 0; n < NEURONS; n++) begin
        weights_q[n]  <= '1;
        membrane_q[n] <= '0;
        refract_q[n]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      inputs_q      <= inputs_d;
      snap_q        <= snap_d;
      threshold_q   <= threshold_d;
      shift_q       <= shift_d;
      refract_len_q <= refract_len_d;
      reset_mode_q  <= reset_mode_d;
      spikes_q      <= spikes_d;
      acc_q         <= acc_d;
      step_done_q   <= step_done_d;
      for (int n = 0; n < NEURONS; n++) begin
        weights_q[n]  <= weights_d[n];
        membrane_q[n] <= membrane_d[n];
        refract_q[n]  <= refract_d[n];
      end
    end
  end

  // Monitor mux; an index beyond the last neuron reads as zero.
  always_comb begin
    mon_value = '0;
    for (int n = 0; n < NEURONS; n++) begin
      if (int'(bus.mon_sel) == n) mon_value = membrane_q[n];
    end
  end

  assign bus.spikes       = spikes_q;
  assign bus.membrane_out = mon_value;
  assign bus.busy         = (state_q == EVAL);
  assign bus.step_done    = step_done_q;

endmodule

// File: tb/tb_lif_layer.sv
// tb_lif_layer
// Self-checking bench for lif_layer: directed scenarios plus randomized
// configurations, all compared against a behavioural model of the layer.
module tb_lif_layer;
  localparam int S    = 32;
  localparam int N    = 4;
  localparam int MB   = 8;
  localparam int MAXM = (1 << (MB - 1)) - 1;
  localparam int MINM = -(1 << (MB - 1));

  logic clk;
  logic reset;

  lif_if #(.NEURONS(N), .MEMBRANE_BITS(MB)) bus ();

  lif_layer #(.SYNAPSES(S), .NEURONS(N), .MEMBRANE_BITS(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit [S-1:0] mInputs;
  bit [S-1:0] mW [N];
  int         mThr, mShift, mRlen, mRmode;
  int         mMem [N];
  int         mRc [N];
  bit [N-1:0] mSpikes;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    mInputs = '0;
    for (int k = 0; k < N; k++) begin
      mW[k]   = '1;
      mMem[k] = 0;
      mRc[k]  = 0;
    end
    mThr = 5; mShift = 0; mRlen = 0; mRmode = 0;
    mSpikes = '0;
  endfunction

  function automatic void modelSetup(input int sel, input int addr, input bit [7:0] data);
    case (sel)
      0: mInputs = {mInputs[S-9:0], data};
      1: mW[addr] = {mW[addr][S-9:0], data};
      2: mThr = int'(data) % (1 << (MB - 1));
      3: mShift = int'(data) % 8;
      4: mRlen = int'(data) % 16;
      5: mRmode = int'(data) % 2;
      default: ;
    endcase
  endfunction

  function automatic void modelStep();
    int sum, m, c;
    for (int k = 0; k < N; k++) begin
      sum = 0;
      for (int i = 0; i < S; i++)
        if (mInputs[i]) sum += mW[k][i] ? 1 : -1;
      if (mRc[k] > 0) begin
        sum = 0;
        mRc[k]--;
      end
      m = mMem[k];
      if (mShift != 0) m = m - (m >>> mShift);
      c = m + sum;
      if (c > MAXM) c = MAXM;
      if (c < MINM) c = MINM;
      if (c >= mThr) begin
        mSpikes[k] = 1'b1;
        mMem[k]    = (mRmode != 0) ? c - mThr : 0;
        mRc[k]     = mRlen;
      end else begin
        mSpikes[k] = 1'b0;
        mMem[k]    = c;
      end
    end
  endfunction

  // One IDLE-time setup write, mirrored into the model.
  task automatic applyStimulus(input int sel, input int addr, input bit [7:0] data);
    @(negedge clk);
    bus.setup_en   = 1'b1;
    bus.setup_sel  = 3'(sel);
    bus.setup_addr = 2'(addr);
    bus.data_in    = data;
    @(negedge clk);
    bus.setup_en   = 1'b0;
    modelSetup(sel, addr, data);
  endtask

  task automatic loadInputs(input bit [31:0] v);
    for (int b = 3; b >= 0; b--) applyStimulus(0, 0, v[8*b +: 8]);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_spikes"}, int'(bus.spikes), int'(mSpikes));
    for (int k = 0; k < N; k++) begin
      bus.mon_sel = 2'(k);
      #1;
      checkOutput($sformatf("%s_mem%0d", tag, k), int'($signed(bus.membrane_out)), mMem[k]);
    end
  endtask

  task automatic startStep();
    @(negedge clk);
    bus.execute = 1'b1;
    @(negedge clk);
    bus.execute = 1'b0;
  endtask

  // Counts busy cycles from the current negedge, then checks the completion.
  task automatic finishStep(input string tag, input int expBusy);
    int cnt = 0;
    int guard = 0;
    while (bus.busy && guard < 50) begin
      cnt++;
      guard++;
      @(negedge clk);
    end
    checkOutput({tag, "_busycycles"}, cnt, expBusy);
    checkOutput({tag, "_done"}, int'(bus.step_done), 1);
    modelStep();
    checkState(tag);
  endtask

  task automatic runStep(input string tag);
    startStep();
    finishStep(tag, N);
    @(negedge clk);
    checkOutput({tag, "_donepulse"}, int'(bus.step_done), 0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.setup_en   = 1'b0;
    bus.setup_sel  = 3'd0;
    bus.setup_addr = '0;
    bus.data_in    = 8'd0;
    bus.execute    = 1'b0;
    bus.mon_sel    = '0;

    // Reset state
    doReset();
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_done", int'(bus.step_done), 0);
    checkState("rst");

    // All-ones weights: every neuron gets +8 against threshold 5
    loadInputs(32'h0000_00FF);
    runStep("ones");
    checkOutput("ones_const", int'(bus.spikes), 4'b1111);

    // Neuron 2 with all-zero weights sees -8
    for (int b = 0; b < 4; b++) applyStimulus(1, 2, 8'h00);
    runStep("sign");
    bus.mon_sel = 2'd2;
    #1;
    checkOutput("sign_const_m2", int'($signed(bus.membrane_out)), -8);

    // Leak plus subtractive reset
    doReset();
    applyStimulus(3, 0, 8'd1);
    applyStimulus(5, 0, 8'd1);
    applyStimulus(2, 0, 8'd5);
    loadInputs(32'h0000_0007);
    runStep("leak1");
    bus.mon_sel = 2'd0;
    #1;
    checkOutput("leak1_const_m0", int'($signed(bus.membrane_out)), 3);
    runStep("leak2");
    checkOutput("leak2_const", int'(bus.spikes), 4'b1111);

    // Refractory period of two steps
    doReset();
    applyStimulus(4, 0, 8'd2);
    loadInputs(32'h0000_00FF);
    for (int s = 1; s <= 4; s++) runStep($sformatf("refr%0d", s));
    checkOutput("refr4_const", int'(bus.spikes), 4'b1111);

    // Saturation at the positive limit
    doReset();
    applyStimulus(2, 0, 8'd127);
    loadInputs(32'hFFFF_FFFF);
    for (int s = 1; s <= 6; s++) begin
      runStep($sformatf("sat%0d", s));
      for (int k = 0; k < N; k++) begin
        bus.mon_sel = 2'(k);
        #1;
        checkOutput($sformatf("sat%0d_nonneg%0d", s, k),
                    int'($signed(bus.membrane_out) < 0), 0);
      end
    end

    // Setup writes and execute while busy are ignored
    doReset();
    loadInputs(32'h0000_00FF);
    startStep();
    bus.setup_en   = 1'b1;
    bus.setup_sel  = 3'd2;
    bus.data_in    = 8'd100;
    bus.execute    = 1'b1;
    @(negedge clk);
    bus.setup_sel  = 3'd1;
    bus.setup_addr = 2'd0;
    bus.data_in    = 8'h00;
    @(negedge clk);
    bus.setup_en   = 1'b0;
    bus.execute    = 1'b0;
    finishStep("blk", 2);
    @(negedge clk);
    checkOutput("blk_idle", int'(bus.busy), 0);
    runStep("blk_after");

    // Reset in the middle of evaluation aborts the step
    startStep();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    checkOutput("abort_busy", int'(bus.busy), 0);
    checkOutput("abort_done", int'(bus.step_done), 0);
    checkState("abort");

    // Execute held in the completion cycle starts the next step at once
    loadInputs(32'h0000_00FF);
    applyStimulus(2, 0, 8'd9);
    startStep();
    finishStep("b2b1", N);
    bus.execute = 1'b1;
    @(negedge clk);
    bus.execute = 1'b0;
    finishStep("b2b2", N);
    checkOutput("b2b2_const", int'(bus.spikes), 4'b1111);

    // Randomized configurations
    for (int r = 0; r < 4; r++) begin
      doReset();
      for (int b = 0; b < 4; b++) applyStimulus(0, 0, 8'($urandom_range(0, 255)));
      for (int k = 0; k < N; k++)
        for (int b = 0; b < 4; b++) applyStimulus(1, k, 8'($urandom_range(0, 255)));
      applyStimulus(2, 0, 8'($urandom_range(0, 255)) & 8'h8F);
      applyStimulus(3, 0, 8'($urandom_range(0, 255)) & 8'hF3);
      applyStimulus(4, 0, 8'($urandom_range(0, 255)) & 8'hF3);
      applyStimulus(5, 0, 8'($urandom_range(0, 255)));
      applyStimulus(6 + (r % 2), 0, 8'($urandom_range(0, 255)));
      for (int s = 0; s < 5; s++) runStep($sformatf("rnd%0d_%0d", r, s));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
